// File: rtl/irq_ctrl_if.sv
// Register bus bundle between the CPU-side bus master and the interrupt controller.
// A request is accepted when reg_valid_i and reg_ready_o are both high; the
// response comes back one cycle later on reg_rvalid_o / reg_rdata_o.
interface irq_ctrl_if;
    logic        reg_valid_i;
    logic        reg_ready_o;
    logic        reg_we_i;
    logic [3:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [31:0] reg_rdata_o;
    logic        reg_rvalid_o;

    modport master (
        output reg_valid_i, reg_we_i, reg_addr_i, reg_wdata_i,
        input  reg_ready_o, reg_rdata_o, reg_rvalid_o
    );

    modport slave (
        input  reg_valid_i, reg_we_i, reg_addr_i, reg_wdata_i,
        output reg_ready_o, reg_rdata_o, reg_rvalid_o
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: NUM_SRC level/edge sources, fixed lowest-ID-wins
// priority, claim/complete handshake through the CLAIM register and a single
// external interrupt line toward the CSR unit.
module irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src_i,
    irq_ctrl_if.slave          reg_bus,
    output logic               ext_irq_o,
    output logic [4:0]         claim_id_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IRQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_EDGE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_CLAIM   = 2'd3;

    state_t             state_q, state_d;
    logic [4:0]         claim_id_d;
    logic [NUM_SRC-1:0] enable_q, edge_sel_q, pend_q, src_q;
    logic [NUM_SRC-1:0] in_service, pend_view, pend_en, rise;
    logic [NUM_SRC-1:0] claim_clr, w1c_clr, pend_d;
    logic [4:0]         winner, claim_val;
    logic [1:0]         addr;
    logic               accept, rd_claim, wr_claim, wr_pend;
    logic               rvalid_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               unused_bits;

    assign addr     = reg_bus.reg_addr_i[3:2];
    assign accept   = reg_bus.reg_valid_i & ~rvalid_q;
    assign rd_claim = accept & ~reg_bus.reg_we_i & (addr == ADDR_CLAIM);
    assign wr_claim = accept &  reg_bus.reg_we_i & (addr == ADDR_CLAIM);
    assign wr_pend  = accept &  reg_bus.reg_we_i & (addr == ADDR_PENDING);

    assign reg_bus.reg_ready_o  = ~rvalid_q;
    assign reg_bus.reg_rvalid_o = rvalid_q;
    assign reg_bus.reg_rdata_o  = rdata_q;
    assign ext_irq_o            = (state_q == IRQ);

    assign unused_bits = ^{reg_bus.reg_addr_i[1:0], reg_bus.reg_wdata_i};

    // Level sources in service are hidden so they cannot re-raise the line; edge bits stay visible.
    assign rise      = irq_src_i & ~src_q;
    assign pend_view = pend_q & ~(in_service & ~edge_sel_q);
    assign pend_en   = pend_view & enable_q;
    assign claim_val = (state_q == IRQ) ? winner : 5'd0;
    assign w1c_clr   = wr_pend ? (reg_bus.reg_wdata_i[NUM_SRC:1] & edge_sel_q) : '0;

    // Decode the in-service ID and the claim-clear mask into per-source one-hot vectors.
    always_comb begin
        in_service = '0;
        claim_clr  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            in_service[k] = (claim_id_o == 5'(k + 1));
            claim_clr[k]  = rd_claim && (state_q == IRQ) && (winner == 5'(k + 1));
        end
    end

    // Fixed-priority arbiter: scan from the top so the lowest enabled pending ID ends up winning.
    always_comb begin
        winner = 5'd0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (pend_en[k]) begin
                winner = 5'(k + 1);
            end
        end
    end

    // Next pending value: level bits follow the line, edge bits latch rises and let a new rise beat any clear.
    always_comb begin
        pend_d = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (edge_sel_q[k]) begin
                pend_d[k] = rise[k] | (pend_q[k] & ~(claim_clr[k] | w1c_clr[k]));
            end else begin
                pend_d[k] = irq_src_i[k];
            end
        end
    end

    // Read-data mux; writes always answer with zero.
    always_comb begin
        rdata_d = '0;
        if (!reg_bus.reg_we_i) begin
            case (addr)
                ADDR_ENABLE:  rdata_d[NUM_SRC:1] = enable_q;
                ADDR_EDGE:    rdata_d[NUM_SRC:1] = edge_sel_q;
                ADDR_PENDING: rdata_d[NUM_SRC:1] = pend_view;
                ADDR_CLAIM:   rdata_d[4:0]       = claim_val;
                default:      rdata_d            = '0;
            endcase
        end
    end

    // Configuration registers, source history, pending bits and the one-cycle response strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q   <= '0;
            edge_sel_q <= '0;
            pend_q     <= '0;
            src_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            src_q    <= irq_src_i;
            pend_q   <= pend_d;
            rvalid_q <= accept;
            rdata_q  <= accept ? rdata_d : 32'd0;
            if (accept && reg_bus.reg_we_i) begin
                case (addr)
                    ADDR_ENABLE: enable_q   <= reg_bus.reg_wdata_i[NUM_SRC:1];
                    ADDR_EDGE:   edge_sel_q <= reg_bus.reg_wdata_i[NUM_SRC:1];
                    default:     ;
                endcase
            end
        end
    end

    // FSM state and in-service ID registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            claim_id_o <= 5'd0;
        end else begin
            state_q    <= state_d;
            claim_id_o <= claim_id_d;
        end
    end

    // Claim/complete sequencing; a claim that finds nothing pending drops straight back to IDLE.
    always_comb begin
        state_d    = state_q;
        claim_id_d = claim_id_o;
        case (state_q)
            IDLE: begin
                if (pend_en != '0) begin
                    state_d = IRQ;
                end
            end
            IRQ: begin
                if (rd_claim) begin
                    if (winner != 5'd0) begin
                        state_d    = SERVICE;
                        claim_id_d = winner;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (pend_en == '0) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (wr_claim && (reg_bus.reg_wdata_i[4:0] == claim_id_o)) begin
                    state_d    = IDLE;
                    claim_id_d = 5'd0;
                end
            end
            default: begin
                state_d    = IDLE;
                claim_id_d = 5'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: a table of register accesses with expected
// read data / ext_irq_o / claim_id_o, followed by hand-written sequences for
// exact interrupt latency, priority, edge re-arm, W1C, disable and reset.
module tb_irq_ctrl;

    localparam int NUM_SRC = 8;
    localparam logic [3:0] A_EN  = 4'h0;
    localparam logic [3:0] A_EDG = 4'h4;
    localparam logic [3:0] A_PND = 4'h8;
    localparam logic [3:0] A_CLM = 4'hC;

    typedef struct {
        string              name;
        logic [NUM_SRC-1:0] src;
        logic               we;
        logic [3:0]         addr;
        logic [31:0]        wdata;
        logic [31:0]        exp_rdata;
        logic               exp_ext;
        logic [4:0]         exp_claim;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SRC-1:0] irq_src;
    logic               ext_irq;
    logic [4:0]         claim_id;
    logic [31:0]        rd;
    int                 checks = 0;
    int                 errors = 0;
    vec_t               vecs[$];

    irq_ctrl_if bus();

    irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src_i  (irq_src),
        .reg_bus    (bus),
        .ext_irq_o  (ext_irq),
        .claim_id_o (claim_id)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One bus access; returns in the response cycle with the read data.
    task automatic apply_stimulus(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata);
        int waited = 0;
        bus.reg_valid_i = 1'b1;
        bus.reg_we_i    = we;
        bus.reg_addr_i  = addr;
        bus.reg_wdata_i = wdata;
        @(negedge clk);
        while (!bus.reg_ready_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.reg_ready_o) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: ready stayed 0, expected 1");
            bus.reg_valid_i = 1'b0;
            rdata = 32'd0;
            return;
        end
        tick();
        bus.reg_valid_i = 1'b0;
        bus.reg_we_i    = 1'b0;
        check_output("rvalid_strobe", 32'(bus.reg_rvalid_o), 32'd1);
        rdata = bus.reg_rdata_o;
    endtask

    task automatic wait_ext(input string name);
        int n = 0;
        while (!ext_irq && n < 20) begin
            tick();
            n++;
        end
        check_output(name, 32'(ext_irq), 32'd1);
    endtask

    task automatic add_vec(input string name, input logic [NUM_SRC-1:0] src, input logic we,
                           input logic [3:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_ext, input logic [4:0] exp_claim);
        vec_t v;
        v.name      = name;
        v.src       = src;
        v.we        = we;
        v.addr      = addr;
        v.wdata     = wdata;
        v.exp_rdata = exp_rdata;
        v.exp_ext   = exp_ext;
        v.exp_claim = exp_claim;
        vecs.push_back(v);
    endtask

    // Directed test sequence.
    initial begin
        rst             = 1'b0;
        irq_src         = '0;
        bus.reg_valid_i = 1'b0;
        bus.reg_we_i    = 1'b0;
        bus.reg_addr_i  = 4'h0;
        bus.reg_wdata_i = 32'd0;

        //        name             src    we  addr   wdata         rdata     ext  claim
        add_vec("en_wr_all",      8'h00, 1, A_EN,  32'hFFFF_FFFF, 32'h0,   0, 0);
        add_vec("en_rd",          8'h00, 0, A_EN,  32'h0,         32'h1FE, 0, 0);
        add_vec("edge_wr",        8'h00, 1, A_EDG, 32'h55,        32'h0,   0, 0);
        add_vec("edge_rd",        8'h00, 0, A_EDG, 32'h0,         32'h54,  0, 0);
        add_vec("edge_rd_alias",  8'h00, 0, 4'h5,  32'h0,         32'h54,  0, 0);
        add_vec("edge_clr",       8'h00, 1, A_EDG, 32'h0,         32'h0,   0, 0);
        add_vec("en_clr",         8'h00, 1, A_EN,  32'h0,         32'h0,   0, 0);
        add_vec("pend_idle",      8'h00, 0, A_PND, 32'h0,         32'h0,   0, 0);
        add_vec("claim_idle",     8'h00, 0, A_CLM, 32'h0,         32'h0,   0, 0);
        add_vec("en_id3",         8'h00, 1, A_EN,  32'h8,         32'h0,   0, 0);
        add_vec("pend_id3",       8'h04, 0, A_PND, 32'h0,         32'h8,   1, 0);
        add_vec("claim_id3",      8'h04, 0, A_CLM, 32'h0,         32'h3,   0, 3);
        add_vec("pend_masked",    8'h04, 0, A_PND, 32'h0,         32'h0,   0, 3);
        add_vec("wrong_cpl",      8'h04, 1, A_CLM, 32'h7,         32'h0,   0, 3);
        add_vec("claim_in_svc",   8'h04, 0, A_CLM, 32'h0,         32'h0,   0, 3);
        add_vec("cpl_id3",        8'h04, 1, A_CLM, 32'h3,         32'h0,   0, 0);
        add_vec("pend_rearm",     8'h04, 0, A_PND, 32'h0,         32'h8,   1, 0);
        add_vec("claim_lost",     8'h00, 0, A_CLM, 32'h0,         32'h0,   0, 0);
        add_vec("pend_zero",      8'h00, 0, A_PND, 32'h0,         32'h0,   0, 0);

        repeat (3) tick();
        check_output("rst_ext", 32'(ext_irq), 32'd0);
        check_output("rst_ready", 32'(bus.reg_ready_o), 32'd1);
        check_output("rst_claim", 32'(claim_id), 32'd0);
        check_output("rst_rvalid", 32'(bus.reg_rvalid_o), 32'd0);
        rst = 1'b1;
        tick();
        check_output("post_rst_ready", 32'(bus.reg_ready_o), 32'd1);

        foreach (vecs[i]) begin
            irq_src = vecs[i].src;
            apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
            check_output({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            check_output({vecs[i].name, "_ext"}, 32'(ext_irq), 32'(vecs[i].exp_ext));
            check_output({vecs[i].name, "_claim"}, 32'(claim_id), 32'(vecs[i].exp_claim));
        end

        // Response strobe lasts one cycle and ready returns.
        tick();
        check_output("rvalid_drop", 32'(bus.reg_rvalid_o), 32'd0);
        check_output("ready_back", 32'(bus.reg_ready_o), 32'd1);

        // Level flow with exact latency; ENABLE is still 0x8 from the table.
        irq_src = 8'h04;
        tick();
        check_output("lvl_ext_n1", 32'(ext_irq), 32'd0);
        tick();
        check_output("lvl_ext_n2", 32'(ext_irq), 32'd1);
        apply_stimulus(1'b0, A_CLM, 32'd0, rd);
        check_output("lvl_claim_rd", rd, 32'd3);
        check_output("lvl_claim_ext", 32'(ext_irq), 32'd0);
        check_output("lvl_claim_id", 32'(claim_id), 32'd3);
        apply_stimulus(1'b1, A_CLM, 32'd3, rd);
        check_output("lvl_cpl_ext", 32'(ext_irq), 32'd0);
        check_output("lvl_cpl_id", 32'(claim_id), 32'd0);
        tick();
        check_output("lvl_rearm_ext", 32'(ext_irq), 32'd1);
        apply_stimulus(1'b0, A_CLM, 32'd0, rd);
        check_output("lvl_reclaim", rd, 32'd3);
        irq_src = 8'h00;
        apply_stimulus(1'b1, A_CLM, 32'd3, rd);
        repeat (3) tick();
        check_output("lvl_quiet", 32'(ext_irq), 32'd0);

        // Priority between IDs 2 and 5.
        apply_stimulus(1'b1, A_EN, 32'h24, rd);
        irq_src = 8'h12;
        wait_ext("pri_ext");
        apply_stimulus(1'b0, A_CLM, 32'd0, rd);
        check_output("pri_first", rd, 32'd2);
        irq_src = 8'h10;
        apply_stimulus(1'b1, A_CLM, 32'd2, rd);
        check_output("pri_cpl_id", 32'(claim_id), 32'd0);
        wait_ext("pri_ext2");
        apply_stimulus(1'b0, A_CLM, 32'd0, rd);
        check_output("pri_second", rd, 32'd5);
        irq_src = 8'h00;
        apply_stimulus(1'b1, A_CLM, 32'd5, rd);
        check_output("pri_cpl5_id", 32'(claim_id), 32'd0);

        // Edge source re-armed by a pulse during service.
        apply_stimulus(1'b1, A_EDG, 32'h10, rd);
        apply_stimulus(1'b1, A_EN, 32'h10, rd);
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        tick();
        check_output("edge_ext_n2", 32'(ext_irq), 32'd1);
        apply_stimulus(1'b0, A_CLM, 32'd0, rd);
        check_output("edge_claim", rd, 32'd4);
        apply_stimulus(1'b0, A_PND, 32'd0, rd);
        check_output("edge_pend_clr", rd, 32'h0);
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        tick();
        apply_stimulus(1'b0, A_PND, 32'd0, rd);
        check_output("edge_pend_svc", rd, 32'h10);
        check_output("edge_ext_svc", 32'(ext_irq), 32'd0);
        apply_stimulus(1'b1, A_CLM, 32'd4, rd);
        tick();
        check_output("edge_ext_cpl", 32'(ext_irq), 32'd1);
        apply_stimulus(1'b0, A_CLM, 32'd0, rd);
        check_output("edge_claim2", rd, 32'd4);
        apply_stimulus(1'b1, A_CLM, 32'd4, rd);

        // W1C clears edge bits only; level ID1 keeps its pending bit.
        apply_stimulus(1'b1, A_EN, 32'h0, rd);
        irq_src = 8'h09;
        tick();
        irq_src = 8'h01;
        tick();
        apply_stimulus(1'b0, A_PND, 32'd0, rd);
        check_output("w1c_pre", rd, 32'h12);
        apply_stimulus(1'b1, A_PND, 32'hFFFF_FFFF, rd);
        apply_stimulus(1'b0, A_PND, 32'd0, rd);
        check_output("w1c_post", rd, 32'h02);
        irq_src = 8'h00;

        // Disable before claim.
        apply_stimulus(1'b1, A_EN, 32'h8, rd);
        irq_src = 8'h04;
        wait_ext("dis_ext_up");
        apply_stimulus(1'b1, A_EN, 32'h0, rd);
        tick();
        check_output("dis_ext_down", 32'(ext_irq), 32'd0);
        apply_stimulus(1'b0, A_CLM, 32'd0, rd);
        check_output("dis_claim", rd, 32'd0);
        check_output("dis_claim_id", 32'(claim_id), 32'd0);

        // Reset while ID 3 is in service.
        apply_stimulus(1'b1, A_EN, 32'h8, rd);
        wait_ext("rst_seq_ext");
        apply_stimulus(1'b0, A_CLM, 32'd0, rd);
        check_output("rst_seq_claim", 32'(claim_id), 32'd3);
        rst = 1'b0;
        #2;
        check_output("rst_mid_ext", 32'(ext_irq), 32'd0);
        check_output("rst_mid_claim", 32'(claim_id), 32'd0);
        check_output("rst_mid_ready", 32'(bus.reg_ready_o), 32'd1);
        irq_src = 8'h00;
        tick();
        rst = 1'b1;
        #1;
        check_output("rst_rel_ext", 32'(ext_irq), 32'd0);
        check_output("rst_rel_ready", 32'(bus.reg_ready_o), 32'd1);
        tick();
        apply_stimulus(1'b0, A_EN, 32'd0, rd);
        check_output("rst_enable", rd, 32'h0);
        apply_stimulus(1'b0, A_EDG, 32'd0, rd);
        check_output("rst_edge", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: run still active, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of interrupt sources (legal 1..31); source IDs are 1..NUM_SRC, and ID 0 means "none".
REQ-002 SHALL have port clk  input  1  core clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port irq_src_i  input  NUM_SRC  interrupt lines, synchronous to clk; bit k-1 is source ID k.
REQ-005 SHALL have port reg_valid_i  input  1  register access request.
REQ-006 SHALL have port reg_ready_o  output  1  access accepted when valid and ready are both high.
REQ-007 SHALL have port reg_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port reg_addr_i  input  4  byte address; only bits [3:2] are decoded.
REQ-009 SHALL have port reg_wdata_i  input  32  write data.
REQ-010 SHALL have port reg_rdata_o  output  32  read data, valid while reg_rvalid_o is high.
REQ-011 SHALL have port reg_rvalid_o  output  1  response strobe.
REQ-012 SHALL have port ext_irq_o  output  1  machine external interrupt request to the CSR unit (irq_i.ext_irq).
REQ-013 SHALL have port claim_id_o  output  5  ID currently in service; 0 when none.

Function
REQ-014 SHALL map registers as follows.
- 0x0 ENABLE: RW, bits [NUM_SRC:1].
- 0x4 EDGE: RW, same layout; 1 = rising-edge source, 0 = level source.
- 0x8 PENDING: read-only, except write-1-to-clear for edge sources only.
- 0xC CLAIM: read = claim, write = complete.
REQ-015 SHALL read bit 0 and bits above NUM_SRC of ENABLE, EDGE and PENDING as 0, and SHALL ignore writes to those bits.
REQ-016 SHALL respond to every accepted access, read or write, with reg_rvalid_o high for exactly 1 cycle in the next cycle.
REQ-017 SHALL drive reg_rdata_o to 0 for writes.
REQ-018 SHALL drive reg_ready_o = ~reg_rvalid_o, so at most one access is outstanding.
REQ-019 SHALL hold a source's level pending bit at the registered irq_src_i, forced to 0 while that ID is in service; this gives 1 cycle of latency.
REQ-020 SHALL set an edge pending bit on a rising edge (irq_src_i high, previous-cycle sample low), including while that ID is in service.
REQ-021 SHALL clear an edge pending bit on claim of that ID or on W1C.
REQ-022 SHALL give set priority over clear when a set coincides with a claim or W1C on the same ID.
REQ-023 SHALL arbitrate with fixed priority: the lowest ID among (PENDING & ENABLE) wins.
REQ-024 SHALL implement a 3-state FSM.
- IDLE: go to IRQ when (PENDING & ENABLE) != 0.
- IRQ: go to SERVICE on an accepted CLAIM read that returns a nonzero ID; go to IDLE if (PENDING & ENABLE) becomes 0.
- SERVICE: go to IDLE on an accepted CLAIM write whose wdata[4:0] equals claim_id_o.
REQ-025 SHALL drive ext_irq_o = (state == IRQ), decoded from the state register only. Source high in cycle N gives pending in N+1 and ext_irq_o in N+2.
REQ-026 SHALL, on a CLAIM read in IRQ, return the winning ID (evaluated in the accept cycle), clear its edge pending bit, and load claim_id_o.
REQ-027 SHALL, on a CLAIM read in IDLE or SERVICE, return 0 with no state change.
REQ-028 SHALL ignore a CLAIM write whose ID does not match, or that arrives outside SERVICE; state and claim_id_o are unchanged.
REQ-029 SHALL clear claim_id_o to 0 on a valid complete.
REQ-030 SHALL accept a complete even if the ID was disabled during service.
REQ-031 SHALL silently ignore unmapped writes; there are none with 4-bit decode.
REQ-032 SHALL use ENABLE and EDGE writes from the next cycle onward.
REQ-033 SHALL give a CLAIM read precedence when it coincides with the loss of all enabled pending in the same cycle: it returns 0 and the FSM goes to IDLE.

Reset
REQ-034 SHALL, while rst is low, asynchronously clear all of the following: ENABLE, EDGE, PENDING, edge-detect history, FSM (to IDLE), claim_id_o, reg_rvalid_o and reg_rdata_o.
REQ-035 SHALL drive ext_irq_o = 0 and reg_ready_o = 1 during and immediately after reset.
REQ-036 SHALL abandon any in-service ID on reset mid-service, with no complete required afterwards.

Verification
REQ-037 SHALL cover reset: assert rst low mid-SERVICE (claim_id_o=3) -> ext_irq_o=0, claim_id_o=0, reg_ready_o=1, ENABLE reads 0x0 after release.
REQ-038 SHALL cover level flow: ENABLE=0x8, irq_src_i=0x04 at cycle N -> ext_irq_o=1 at N+2.
- CLAIM read returns 3, ext_irq_o=0, claim_id_o=3.
- Write 3 to CLAIM -> ext_irq_o=1 again 1 cycle later while the line is still high.
REQ-039 SHALL cover priority: ENABLE=0x24, irq_src_i=0x12 (IDs 2 and 5) -> claim returns 2; after complete(2) and line 2 dropped, claim returns 5.
REQ-040 SHALL cover edge re-arm: EDGE=ENABLE=0x10, 1-cycle pulse on ID 4 -> claim returns 4, PENDING=0x0.
- A second pulse during service -> PENDING=0x10 and ext_irq_o stays 0.
- Complete(4) -> ext_irq_o=1.
REQ-041 SHALL cover a wrong complete: in SERVICE with ID 3, write 7 to CLAIM -> claim_id_o stays 3 and a CLAIM read returns 0.
REQ-042 SHALL cover disable before claim: in IRQ, write ENABLE=0x0 -> ext_irq_o=0 the next cycle and a CLAIM read returns 0.
